// File: rtl/count_sched.sv
// Round-robin scheduler sharing one 8-bit popcount unit among NREQ requesters.
// Words are streamed through the unit one byte per cycle, LSB first, and the total is returned with the requester ID.
module count_sched #(
   parameter int NREQ       = 4,
   parameter int WORD_BYTES = 4,
   parameter int ID_W       = $clog2(NREQ),
   parameter int CNT_W      = $clog2(8*WORD_BYTES+1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*8*WORD_BYTES-1:0] req_data,
   output logic [NREQ-1:0]              req_ready,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [CNT_W-1:0]             res_count,
   output logic [ID_W-1:0]              res_id,
   output logic                         busy
);

   localparam int WORD_W = 8*WORD_BYTES;
   localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [WORD_W-1:0]   shift_reg, shift_next;
   logic [CNT_W-1:0]    acc_reg, acc_next;
   logic [ID_W-1:0]     id_reg, id_next;
   logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [BC_W-1:0]     byte_cnt_reg, byte_cnt_next;

   logic [WORD_W-1:0]   req_word [NREQ];
   logic [NREQ-1:0]     grant;
   logic [ID_W-1:0]     grant_id;
   logic                grant_found;
   logic [WORD_W-1:0]   grant_word;
   logic [3:0]          byte_ones;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign req_word[gi] = req_data[gi*WORD_W +: WORD_W];
   end

   // Shared popcount unit: always looks at the low byte of the shift register.
   if (1'b1) begin : count
      logic [7:0] data_in;
      logic [3:0] count_out;

      assign data_in = shift_reg[7:0];

      always_comb begin
         count_out = '0;
         for (int b = 0; b < 8; b++) begin
            count_out = count_out + {3'b000, data_in[b]};
         end
      end

      assign byte_ones = count_out;
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && req_valid[j] &&
                (j == ((int'(rr_ptr_reg) + k) % NREQ))) begin
               grant_found = 1'b1;
               grant_id    = ID_W'(j);
            end
         end
      end
   end

   always_comb begin
      grant      = '0;
      grant_word = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant_found && (grant_id == ID_W'(j))) begin
            grant[j]   = 1'b1;
            grant_word = req_word[j];
         end
      end
   end

   // Gated with rst_n so the grant disappears the moment reset is asserted.
   assign req_ready = (rst_n && state_reg == IDLE) ? grant : '0;
   assign res_valid = (state_reg == DONE);
   assign res_count = acc_reg;
   assign res_id    = id_reg;
   assign busy      = (state_reg != IDLE);

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      acc_next      = acc_reg;
      id_next       = id_reg;
      rr_ptr_next   = rr_ptr_reg;
      byte_cnt_next = byte_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               shift_next    = grant_word;
               id_next       = grant_id;
               acc_next      = '0;
               byte_cnt_next = '0;
               rr_ptr_next   = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
               state_next    = RUN;
            end
         end
         RUN: begin
            acc_next      = acc_reg + CNT_W'(byte_ones);
            shift_next    = shift_reg >> 8;
            byte_cnt_next = byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == BC_W'(WORD_BYTES-1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         acc_reg      <= '0;
         id_reg       <= '0;
         rr_ptr_reg   <= '0;
         byte_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         acc_reg      <= acc_next;
         id_reg       <= id_next;
         rr_ptr_reg   <= rr_ptr_next;
         byte_cnt_reg <= byte_cnt_next;
      end
   end

endmodule

// File: tb/tb_count_sched.sv
// Scoreboard bench for count_sched: a cycle-level reference model predicts grants and results,
// a separate monitor compares every presented result against the expectation queue.
module tb_count_sched;

   localparam int NREQ  = 4;
   localparam int WB    = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 6;
   localparam int WW    = 8*WB;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*WW-1:0]   req_data = '0;
   logic [NREQ-1:0]      req_ready;
   logic                 res_valid;
   logic                 res_ready = 1'b1;
   logic [CNT_W-1:0]     res_count;
   logic [ID_W-1:0]      res_id;
   logic                 busy;

   always #5 clk = ~clk;

   count_sched #(.NREQ(NREQ), .WORD_BYTES(WB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_count(res_count), .res_id(res_id), .busy(busy)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct { int id; int cnt; } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [WW-1:0] rand_word();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return '1;
         default: return WW'($urandom);
      endcase
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Reference model: round-robin arbitration and job timing derived from the rules, not the RTL.
   typedef enum {M_IDLE, M_RUN, M_DONE} m_state_t;
   m_state_t m_state = M_IDLE;
   int m_ptr = 0;
   int m_cnt = 0;

   initial begin
      int g;
      logic [NREQ-1:0] er;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_state = M_IDLE;
            m_ptr   = 0;
         end else begin
            case (m_state)
               M_IDLE: begin
                  g  = -1;
                  er = '0;
                  for (int k = 0; k < NREQ; k++) begin
                     if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                  end
                  if (g >= 0) er[g] = 1'b1;
                  check("req_ready_idle", req_ready, er);
                  check("busy_idle", busy, 0);
                  check("res_valid_idle", res_valid, 0);
                  if (g >= 0) begin
                     exp_q.push_back('{g, $countones(req_data[g*WW +: WW])});
                     m_ptr   = (g + 1) % NREQ;
                     m_cnt   = 0;
                     m_state = M_RUN;
                  end
               end
               M_RUN: begin
                  check("req_ready_run", req_ready, 0);
                  check("busy_run", busy, 1);
                  check("res_valid_run", res_valid, 0);
                  m_cnt++;
                  if (m_cnt == WB) m_state = M_DONE;
               end
               default: begin
                  check("req_ready_done", req_ready, 0);
                  check("busy_done", busy, 1);
                  check("res_valid_done", res_valid, 1);
                  if (res_ready) m_state = M_IDLE;
               end
            endcase
         end
      end
   end

   // Monitor: every cycle a result is shown it must match the queue head (covers back-pressure stability).
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
               check("res_unexpected", 1, 0);
            end else begin
               check("res_id", res_id, exp_q[0].id);
               check("res_count", res_count, exp_q[0].cnt);
               if (res_ready) begin
                  $display("result id=%0d count=%0d expected id=%0d count=%0d",
                           res_id, res_count, exp_q[0].id, exp_q[0].cnt);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      next_cycle();
      rst_n = 1'b1;
   endtask

   // Directed single job with explicit expected count and latency.
   task automatic run_job(input int i, input logic [WW-1:0] d, input int exp_cnt);
      int n;
      bit ok;
      req_data[i*WW +: WW] = d;
      req_valid[i] = 1'b1;
      ok = 0;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready[i]) begin ok = 1; break; end
      end
      check("job_accept", ok, 1);
      next_cycle();
      req_valid[i] = 1'b0;
      ok = 0;
      for (n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (res_valid) begin ok = 1; break; end
      end
      check("job_result_seen", ok, 1);
      check("job_latency", n, WB + 1);
      check("job_count", res_count, exp_cnt);
      check("job_id", res_id, i);
      next_cycle();
      @(negedge clk);
      check("job_busy_after", busy, 0);
      next_cycle();
   endtask

   initial begin
      logic [NREQ-1:0] acc;
      logic [CNT_W-1:0] hold_cnt;
      logic [ID_W-1:0]  hold_id;
      int got;
      bit ok;

      // Reset state, with requesters already valid.
      req_valid = 4'hF;
      req_data  = '1;
      #3;
      check("rst_req_ready", req_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_count", res_count, 0);
      check("rst_res_id", res_id, 0);
      check("rst_busy", busy, 0);
      req_valid = '0;
      @(negedge clk);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      run_job(0, 32'hFFFF_FFFF, 32);
      run_job(2, 32'hAACC_8136, 14);
      run_job(2, 32'h0000_0000, 0);

      // Round-robin with all requesters continuously valid.
      pulse_reset();
      for (int i = 0; i < NREQ; i++) req_data[i*WW +: WW] = rand_word();
      req_valid = 4'hF;
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ok = 0;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != 0) begin ok = 1; break; end
         end
         got = onehot_idx(req_ready);
         check("rr_order", got, k % NREQ);
         next_cycle();
      end

      // Back-pressure: result held for 10 cycles.
      ok = 0;
      res_ready = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (res_valid) begin ok = 1; break; end
      end
      check("bp_result_seen", ok, 1);
      hold_cnt = res_count;
      hold_id  = res_id;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("bp_valid", res_valid, 1);
         check("bp_count_stable", res_count, hold_cnt);
         check("bp_id_stable", res_id, hold_id);
         check("bp_req_ready", req_ready, 0);
      end
      next_cycle();
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake", res_valid, 1);
      @(negedge clk);
      check("bp_next_accept", req_ready != 0, 1);
      next_cycle();
      req_valid = '0;
      repeat (WB + 3) next_cycle();

      // Reset two cycles after an accept.
      req_data[3*WW +: WW] = '1;
      req_valid = 4'b1000;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready[3]) begin ok = 1; break; end
      end
      check("mid_accept", ok, 1);
      next_cycle();
      req_valid = 4'b0110;
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("mid_req_ready", req_ready, 0);
      check("mid_res_valid", res_valid, 0);
      check("mid_res_count", res_count, 0);
      check("mid_res_id", res_id, 0);
      check("mid_busy", busy, 0);
      @(negedge clk);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_next_grant", req_ready, 4'b0010);
      next_cycle();
      req_valid = '0;
      repeat (WB + 3) next_cycle();

      // Skip: req1 drops before its turn, req3 wins, pointer wraps to 0.
      pulse_reset();
      req_valid = 4'b0001;
      @(negedge clk);
      next_cycle();
      req_valid = 4'b1010;
      repeat (WB - 1) next_cycle();
      req_valid = 4'b1000;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready != 0) begin ok = 1; break; end
      end
      check("skip_grant", onehot_idx(req_ready), 3);
      next_cycle();
      req_valid = 4'b1011;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready != 0) break;
      end
      check("skip_ptr_wrap", onehot_idx(req_ready), 0);
      next_cycle();
      req_valid = '0;
      repeat (WB + 3) next_cycle();

      // Randomized traffic obeying the hold-until-accepted rule.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         next_cycle();
         res_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 9) < 4);
               req_data[i*WW +: WW] = rand_word();
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      res_ready = 1'b1;
      repeat (3*WB + 5) next_cycle();
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that shares a single 8-bit `count` popcount unit among `NREQ` requesters. Each requester submits a multi-byte word over a valid/ready handshake. The scheduler grants one requester at a time and feeds the word through the shared `count` instance one byte per cycle, least-significant byte first. It accumulates the per-byte counts and returns the total population count, tagged with the requester ID, over a second valid/ready handshake. The block sits between the requesting agents and the `count` datapath, which it instantiates internally.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WORD_BYTES`, 4: bytes per submitted word (1..8).
- `ID_W`, `$clog2(NREQ)`: width of the requester ID.
- `CNT_W`, `$clog2(8*WORD_BYTES+1)`: width of the total count (6 at the defaults).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NREQ`: per-requester job valid.
- `req_data`, input, `NREQ*8*WORD_BYTES`: per-requester word; requester i occupies slice `[i*8*WORD_BYTES +: 8*WORD_BYTES]`.
- `req_ready`, output, `NREQ`: one-hot grant/accept; at most one bit is high.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_count`, output, `CNT_W`: total number of ones in the accepted word.
- `res_id`, output, `ID_W`: index of the requester that owns the result.
- `busy`, output, 1: high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready` is the combinational round-robin grant over `req_valid`, starting from pointer `rr_ptr`.
  - On accept (`req_valid[i] & req_ready[i]`):
    - capture `req_data` slice i into a shift register;
    - set `res_id` to i;
    - clear the accumulator;
    - set `rr_ptr` to (i+1) mod `NREQ`;
    - go to RUN.
  - With no valid request, stay in IDLE and hold `req_ready` at 0.
- **RUN**
  - The low byte of the shift register drives `count.data_in`.
  - Each cycle: accumulator += `count_out` (zero-extended to `CNT_W`); the shift register shifts right by 8; a byte counter increments.
  - After `WORD_BYTES` cycles, go to DONE.
  - `req_ready` is 0.
- **DONE**
  - `res_valid` is 1; `res_count` shows the accumulator.
  - `res_count` and `res_id` hold stable until `res_valid & res_ready`, then the FSM returns to IDLE.
  - `req_ready` is 0.
- **Arithmetic:** the accumulator is `CNT_W` bits. Overflow cannot occur, because the maximum is 8*`WORD_BYTES`.
- **Requester rules:** `req_valid` must hold, with stable data, until accepted. Deasserting valid before accept is allowed; that requester is simply skipped.
- **Fairness:** a requester that is continuously valid is granted within `NREQ` jobs.
- **Reset** (asynchronous, any state, including mid-RUN or DONE):
  - state goes to IDLE and any in-flight job is discarded with no result;
  - `req_ready`, `res_valid`, `res_count`, `res_id`, `busy` and `rr_ptr` are all 0.

## Timing

- Accept in cycle T. Bytes 0..`WORD_BYTES`-1 reach `count` in cycles T+1..T+`WORD_BYTES`.
- `res_valid` rises at T+`WORD_BYTES`+1, so accept-to-result latency is `WORD_BYTES`+1 cycles.
- If the result handshake completes in cycle D, the next accept can occur in cycle D+1. Minimum job spacing is `WORD_BYTES`+2 cycles.
- `busy` is registered: high from T+1 through D, low from D+1.
- `res_ready` high while not in DONE has no effect.
- `req_valid` changing during RUN or DONE has no effect; arbitration is evaluated only in IDLE.

## Test plan

- **Single job, all ones.** Reset, then req0 valid with data 0xFFFFFFFF.
  - Accept at T.
  - `res_valid` at T+5 with `res_count`=32 and `res_id`=0.
  - `busy` falls the cycle after the handshake.
- **Mixed bytes.** req2 submits 0xAACC8136, whose bytes are 0x36, 0x81, 0xCC, 0xAA.
  - Required result: `res_count`=14, `res_id`=2.
  - Submitting 0x00000000 returns `res_count`=0.
- **Round-robin.** All four requesters valid continuously, `res_ready`=1.
  - Grant order 0,1,2,3,0.
  - `req_ready` is one-hot and high only in IDLE cycles.
- **Back-pressure.** Hold `res_ready`=0 for 10 cycles in DONE.
  - `res_valid`, `res_count` and `res_id` stay stable.
  - `req_ready` stays all zero.
  - Raising `res_ready` completes the handshake and the next job is accepted one cycle later.
- **Reset mid-RUN.** Assert `rst_n`=0 two cycles after an accept.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No `res_valid` appears after release.
  - The next grant goes to the lowest-index valid requester.
- **Skip.** req1 valid, then deasserted before grant while req3 stays valid.
  - req3 is granted, and `rr_ptr` then points to 0.
